// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch sequencer in front of the UART transmitter: buffers host bytes,
// strobes one byte at a time into the transmitter and waits for its done edge or a watchdog.
module uart_tx_fifo #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    din,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          wr_data,
  output logic [7:0]    tx_data,
  input  logic          donet,
  output logic          busy,
  output logic          overflow,
  output logic          timeout_err,
  input  logic          clr_err
);

  localparam int          WDW     = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [WDW-1:0]  r_wd;
  logic            r_done_q;
  logic            w_done_evt;
  logic            w_pop;
  logic            w_push;
  logic            w_reject;
  logic            w_wd_fire;
  logic [AW:0]     w_count_nxt;

  assign w_done_evt = donet & ~r_done_q;

  // Next-state decode; a pop only ever happens on the IDLE to LAUNCH step
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_wd_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LAUNCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done_evt) begin
          w_state_nxt = S_IDLE;
        end else if (r_wd == WD_LAST) begin
          w_wd_fire   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write acceptance and occupancy update
  always_comb begin
    w_push      = wr_en & ((count != DEPTH_C) | w_pop);
    w_reject    = wr_en & ~w_push;
    w_count_nxt = count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = count + (AW + 1)'(1);
      2'b01:   w_count_nxt = count - (AW + 1)'(1);
      default: w_count_nxt = count;
    endcase
  end

  // Storage array; not reset, validity is tracked by the pointers and count
  always_ff @(posedge clk1) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Control state, pointers, registered outputs, watchdog and sticky errors
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_wd        <= '0;
      r_done_q    <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      wr_data     <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_done_q <= donet;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        tx_data  <= r_mem[r_rd_ptr];
      end
      count   <= w_count_nxt;
      full    <= (w_count_nxt == DEPTH_C);
      empty   <= (w_count_nxt == '0);
      wr_data <= (w_state_nxt == S_LAUNCH);
      busy    <= (w_state_nxt != S_IDLE);
      if (r_state == S_LAUNCH) begin
        r_wd <= '0;
      end else if (r_state == S_WAIT) begin
        r_wd <= r_wd + WDW'(1);
      end
      // A new error event in the same cycle as clr_err takes priority
      if (w_reject) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (w_wd_fire) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and launch sequencer directly upstream of the UART transmitter inside uart_top_module.
- Accepts bytes from the host side into a DEPTH-entry FIFO.
- Presents one byte at a time to the transmitter on tx_data with a one-cycle wr_data strobe, then waits for the transmitter's done indication before launching the next byte.
- Guards against a hung transmitter with a watchdog.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, 2 to 256.
- AW, 4, address width, log2(DEPTH).
- TIMEOUT, 200000, clk1 cycles allowed in WAIT_DONE before the watchdog fires (one frame at the slowest baud plus margin).

Ports:
- clk1 input 1: single clock (transmit-side clock); all logic on its rising edge.
- rst input 1: asynchronous, active-high reset.
- wr_en input 1: host write strobe; din captured on the clk1 edge when wr_en=1 and the write is accepted.
- din input 8: host byte.
- full output 1: count==DEPTH.
- empty output 1: count==0.
- count output AW+1: bytes stored, 0..DEPTH; excludes the byte in flight.
- wr_data output 1: one-cycle launch strobe to the transmitter.
- tx_data output 8: byte to the transmitter; stable from the wr_data cycle until done is seen.
- donet input 1: transmitter done; level or pulse, synchronous to clk1.
- busy output 1: 1 while a byte is in flight (LAUNCH or WAIT_DONE).
- overflow output 1: sticky; set by a rejected write.
- timeout_err output 1: sticky; set by the watchdog.
- clr_err input 1: synchronously clears overflow and timeout_err.

Behaviour:
Reset:
- Asserting rst clears, asynchronously: pointers, count=0, empty=1, full=0, wr_data=0, tx_data=8'h00, busy=0, overflow=0, timeout_err=0.
- State returns to IDLE and the watchdog counter is cleared.
- Reset mid-frame discards all stored bytes and the in-flight byte.

FIFO:
- Circular buffer with AW-bit read and write pointers that wrap DEPTH-1 to 0. count is tracked separately.
- Write accepted when wr_en=1 and (count<DEPTH, or a pop occurs in the same cycle).
- Write with wr_en=1 while full and no pop that cycle: rejected, din dropped, overflow set to 1, count unchanged.
- Pop happens only on the IDLE to LAUNCH transition.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- Empty FIFO never pops; there is no read-while-empty path.

Done detection:
- donet is registered once (done_q).
- done_evt = donet & ~done_q (rising edge), so a level-style done counts once.

State machine (IDLE, LAUNCH, WAIT_DONE):
- IDLE: if count>0, pop the head into tx_data and go to LAUNCH. Otherwise stay.
- Latency: a byte written into an empty FIFO while IDLE appears on tx_data at edge N+1 (the next edge) and wr_data=1 for the cycle following it.
- LAUNCH: wr_data=1 for exactly this one cycle. Go to WAIT_DONE and clear the watchdog.
- WAIT_DONE: wr_data=0 and tx_data held. The watchdog increments each cycle.
  - On done_evt, go to IDLE. The next byte, if any, launches with a gap of exactly 1 IDLE cycle between done_evt and the next LAUNCH state.
  - If the watchdog reaches TIMEOUT-1 without done_evt, set timeout_err=1 and go to IDLE. The in-flight byte is abandoned and not retried.
- A done_evt outside WAIT_DONE is ignored.
- busy = (state != IDLE).

Errors:
- clr_err=1 clears overflow and timeout_err on the next edge.
- If clr_err and a new error event occur in the same cycle, set wins.

Test Plan:
- Reset then single byte: release rst, write 8'hAA in one cycle → next edge tx_data=8'hAA; wr_data high exactly 1 cycle one cycle later; busy=1; count=0; empty=1. Pulse donet → busy=0 two edges later.
- Burst order: write 8'h01..8'h05 on consecutive cycles; answer each wr_data with a 1-cycle donet 20 cycles later → tx_data sequence 01,02,03,04,05; 5 wr_data strobes; 1 IDLE cycle between done and next LAUNCH; count peaks at 4.
- Full and overflow (DEPTH=16): hold donet=0 with TIMEOUT large; write 18 bytes 8'h10..8'h21 → first byte in flight, count=16, full=1 after the 17th write, 18th byte (8'h21) dropped, overflow=1. Drain with donet → 17 bytes out in order, 8'h21 never appears. clr_err → overflow=0.
- Level done and simultaneous write/pop: donet held high for 10 cycles → exactly one byte completes per rising edge. At full, write in the same cycle as the pop → write accepted, count stays 16, full stays 1, overflow stays 0.
- Watchdog (TIMEOUT=50): write 8'h55 and 8'h66, never assert donet → timeout_err=1 after 50 cycles in WAIT_DONE; state returns to IDLE; 8'h66 launches next.
- Reset mid-frame: 3 bytes queued, one in flight; assert rst between clk1 edges → outputs clear immediately; after release, no wr_data occurs without new writes.
